// File: rtl/id_scanner.sv
// id_scanner: streaming identifier recogniser. It consumes one ASCII character
// per valid cycle. It tracks whether the accepted stream ends in letters
// followed by 1..MAX_DIGITS digits, and counts how many such identifiers it has
// recognised. The counter saturates at its maximum value.
// Optional build macro: ID_SCANNER_UNDERSCORE_EN treats '_' (0x5F) as a letter.
module id_scanner #(
    parameter int unsigned MAX_DIGITS = 8,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [7:0]                          char,
    input  logic                                char_valid,
    output logic                                out,
    output logic [1:0]                          state,
    output logic [$clog2(MAX_DIGITS+1)-1:0]     digit_cnt,
    output logic [CNT_W-1:0]                    match_cnt
);

    localparam int unsigned       DW      = $clog2(MAX_DIGITS + 1);
    localparam logic [DW-1:0]     DIG_MAX = DW'(MAX_DIGITS);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ALPHA = 2'd1,
        S_DIGIT = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    state_t           cur_state;
    state_t           nxt_state;
    logic [DW-1:0]    dcnt_q;
    logic [DW-1:0]    dcnt_d;
    logic [CNT_W-1:0] mcnt_q;
    logic [CNT_W-1:0] mcnt_d;
    logic             out_q;
    logic             out_d;
    logic             is_letter;
    logic             is_digit;

    // Character classification; anything that is neither letter nor digit is a separator.
    always_comb begin
        is_letter = ((char >= 8'h61) && (char <= 8'h7A)) ||
                    ((char >= 8'h41) && (char <= 8'h5A));
`ifdef ID_SCANNER_UNDERSCORE_EN
        is_letter = is_letter || (char == 8'h5F);
`else
        is_letter = is_letter;
`endif
        is_digit  = (char >= 8'h30) && (char <= 8'h39);
    end

    // Next-state, digit-run and match-count logic; everything holds when char_valid is low.
    always_comb begin
        nxt_state = cur_state;
        dcnt_d    = dcnt_q;
        mcnt_d    = mcnt_q;
        if (char_valid) begin
            case (cur_state)
                S_IDLE: begin
                    if (is_letter) begin
                        nxt_state = S_ALPHA;
                    end else if (is_digit) begin
                        nxt_state = S_ERR;
                    end else begin
                        nxt_state = S_IDLE;
                    end
                    dcnt_d = '0;
                end
                S_ALPHA: begin
                    if (is_letter) begin
                        nxt_state = S_ALPHA;
                        dcnt_d    = '0;
                    end else if (is_digit) begin
                        nxt_state = S_DIGIT;
                        dcnt_d    = DW'(1);
                        if (mcnt_q != CNT_MAX) begin
                            mcnt_d = mcnt_q + 1'b1;
                        end
                    end else begin
                        nxt_state = S_IDLE;
                        dcnt_d    = '0;
                    end
                end
                S_DIGIT: begin
                    if (is_digit) begin
                        if (dcnt_q < DIG_MAX) begin
                            nxt_state = S_DIGIT;
                            dcnt_d    = dcnt_q + 1'b1;
                        end else begin
                            nxt_state = S_ERR;
                            dcnt_d    = '0;
                        end
                    end else if (is_letter) begin
                        nxt_state = S_ALPHA;
                        dcnt_d    = '0;
                    end else begin
                        nxt_state = S_IDLE;
                        dcnt_d    = '0;
                    end
                end
                S_ERR: begin
                    if (is_letter) begin
                        nxt_state = S_ALPHA;
                    end else if (is_digit) begin
                        nxt_state = S_ERR;
                    end else begin
                        nxt_state = S_IDLE;
                    end
                    dcnt_d = '0;
                end
                default: begin
                    nxt_state = S_IDLE;
                    dcnt_d    = '0;
                end
            endcase
        end
        out_d = (nxt_state == S_DIGIT);
    end

    // State and counter registers with synchronous reset; updates gated by char_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= S_IDLE;
            dcnt_q    <= '0;
            mcnt_q    <= '0;
            out_q     <= 1'b0;
        end else if (char_valid) begin
            cur_state <= nxt_state;
            dcnt_q    <= dcnt_d;
            mcnt_q    <= mcnt_d;
            out_q     <= out_d;
        end
    end

    assign out       = out_q;
    assign state     = cur_state;
    assign digit_cnt = dcnt_q;
    assign match_cnt = mcnt_q;

endmodule

// File: tb/tb_id_scanner.sv
// tb_id_scanner: directed vectors with hand-computed expectations. Instance A
// uses the default parameters. Instance B uses MAX_DIGITS=3 and CNT_W=2. The
// driver pushes each expected response into a scoreboard queue, and a separate
// monitor pops and compares it once the DUT output is due.
module tb_id_scanner;

    logic        clk = 1'b0;
    int          cyc = 0;

    logic        rst_a = 1'b0, vld_a = 1'b0;
    logic [7:0]  ch_a  = '0;
    logic        out_a;
    logic [1:0]  st_a;
    logic [3:0]  dc_a;
    logic [15:0] mc_a;

    logic        rst_b = 1'b0, vld_b = 1'b0;
    logic [7:0]  ch_b  = '0;
    logic        out_b;
    logic [1:0]  st_b;
    logic [1:0]  dc_b;
    logic [1:0]  mc_b;

`ifdef ID_SCANNER_UNDERSCORE_EN
    localparam int UND_ST = 1;
`else
    localparam int UND_ST = 0;
`endif

    id_scanner dut_a (
        .clk(clk), .reset(rst_a), .char(ch_a), .char_valid(vld_a),
        .out(out_a), .state(st_a), .digit_cnt(dc_a), .match_cnt(mc_a)
    );

    id_scanner #(.MAX_DIGITS(3), .CNT_W(2)) dut_b (
        .clk(clk), .reset(rst_b), .char(ch_b), .char_valid(vld_b),
        .out(out_b), .state(st_b), .digit_cnt(dc_b), .match_cnt(mc_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit    which;
        int    tgt;
        int    st;
        int    o;
        int    dc;
        int    mc;
        string nm;
    } exp_t;

    exp_t sb[$];
    int   n_checks  = 0;
    int   n_fail    = 0;
    bit   stim_done = 1'b0;
    int   late_cnt  = 0;

    task automatic step(input bit w, input bit rst, input bit vld, input logic [7:0] c,
                        input int st, input int o, input int dc, input int mc,
                        input string nm);
        exp_t e;
        @(negedge clk);
        rst_a = 1'b0; vld_a = 1'b0; ch_a = '0;
        rst_b = 1'b0; vld_b = 1'b0; ch_b = '0;
        if (w == 1'b0) begin
            rst_a = rst; vld_a = vld; ch_a = c;
        end else begin
            rst_b = rst; vld_b = vld; ch_b = c;
        end
        e.which = w; e.tgt = cyc + 1;
        e.st = st; e.o = o; e.dc = dc; e.mc = mc; e.nm = nm;
        sb.push_back(e);
    endtask

    // Monitor: pops each expected entry at the negedge after its vector was clocked in.
    always @(negedge clk) begin
        int ast, ao, adc, amc;
        exp_t e;
        while (sb.size() > 0 && sb[0].tgt <= cyc) begin
            e = sb.pop_front();
            if (e.which == 1'b0) begin
                ast = int'(st_a); ao = int'(out_a); adc = int'(dc_a); amc = int'(mc_a);
            end else begin
                ast = int'(st_b); ao = int'(out_b); adc = int'(dc_b); amc = int'(mc_b);
            end
            n_checks++;
            if (e.tgt != cyc || ast != e.st || ao != e.o || adc != e.dc || amc != e.mc) begin
                n_fail++;
                $display("FAIL %s (dut %0d): got state=%0d out=%0d digit_cnt=%0d match_cnt=%0d, required state=%0d out=%0d digit_cnt=%0d match_cnt=%0d",
                         e.nm, e.which, ast, ao, adc, amc, e.st, e.o, e.dc, e.mc);
            end
        end
        if (stim_done && sb.size() != 0) begin
            late_cnt++;
            if (late_cnt > 10) begin
                $display("FAIL drain_timeout: %0d entries pending, required 0", sb.size());
                n_checks += sb.size();
                n_fail   += sb.size();
                sb.delete();
            end
        end
    end

    initial begin
        // Instance A, default parameters.
        step(0, 1, 0, "x", 0, 0, 0, 0, "reset_a");
        // "ab12"
        step(0, 0, 1, "a", 1, 0, 0, 0, "ab12_a");
        step(0, 0, 1, "b", 1, 0, 0, 0, "ab12_b");
        step(0, 0, 1, "1", 2, 1, 1, 1, "ab12_1");
        step(0, 0, 1, "2", 2, 1, 2, 1, "ab12_2");
        // "9a1 "
        step(0, 1, 0, "x", 0, 0, 0, 0, "reset_2");
        step(0, 0, 1, "9", 3, 0, 0, 0, "9a1_9");
        step(0, 0, 1, "a", 1, 0, 0, 0, "9a1_a");
        step(0, 0, 1, "1", 2, 1, 1, 1, "9a1_1");
        step(0, 0, 1, " ", 0, 0, 0, 1, "9a1_sp");
        // "a1" with idle gaps, then reset mid-DIGIT
        step(0, 1, 0, "x", 0, 0, 0, 0, "reset_3");
        step(0, 0, 1, "a", 1, 0, 0, 0, "gap_a");
        for (int i = 0; i < 5; i++) step(0, 0, 0, "7", 1, 0, 0, 0, "gap_hold_alpha");
        step(0, 0, 1, "1", 2, 1, 1, 1, "gap_1");
        for (int i = 0; i < 5; i++) step(0, 0, 0, "z", 2, 1, 1, 1, "gap_hold_digit");
        step(0, 1, 1, "5", 0, 0, 0, 0, "reset_mid_digit");
        step(0, 0, 1, "3", 3, 0, 0, 0, "post_reset_digit");
        // "_a1"
        step(0, 1, 0, "x", 0, 0, 0, 0, "reset_4");
        step(0, 0, 1, "_", UND_ST, 0, 0, 0, "und__");
        step(0, 0, 1, "a", 1, 0, 0, 0, "und_a");
        step(0, 0, 1, "1", 2, 1, 1, 1, "und_1");
        // Default MAX_DIGITS=8 overflow, then ERR/DIGIT exits and class boundaries
        step(0, 1, 0, "x", 0, 0, 0, 0, "reset_5");
        step(0, 0, 1, "q", 1, 0, 0, 0, "ovf_q");
        for (int i = 1; i <= 8; i++) step(0, 0, 1, 8'(8'h30 + i), 2, 1, i, 1, "ovf_digit");
        step(0, 0, 1, "9", 3, 0, 0, 1, "ovf_9th");
        step(0, 0, 1, "5", 3, 0, 0, 1, "err_digit");
        step(0, 0, 1, "k", 1, 0, 0, 1, "err_letter");
        step(0, 0, 1, "0", 2, 1, 1, 2, "digit_0");
        step(0, 0, 1, "r", 1, 0, 0, 2, "digit_letter");
        step(0, 0, 1, "9", 2, 1, 1, 3, "digit_9");
        step(0, 0, 1, ":", 0, 0, 0, 3, "colon_sep");
        step(0, 0, 1, "Z", 1, 0, 0, 3, "upper_Z");
        step(0, 0, 1, 8'h60, 0, 0, 0, 3, "backtick_sep");
        step(0, 0, 1, "z", 1, 0, 0, 3, "lower_z");
        step(0, 0, 1, "{", 0, 0, 0, 3, "brace_sep");
        step(0, 0, 1, "A", 1, 0, 0, 3, "upper_A");
        step(0, 0, 1, "/", 0, 0, 0, 3, "slash_sep");
        step(0, 0, 1, "@", 0, 0, 0, 3, "at_sep");
        step(0, 0, 1, "m", 1, 0, 0, 3, "lower_m");
        step(0, 0, 1, "[", 0, 0, 0, 3, "bracket_sep");

        // Instance B, MAX_DIGITS=3, CNT_W=2.
        step(1, 1, 0, "x", 0, 0, 0, 0, "reset_b");
        step(1, 0, 1, "x", 1, 0, 0, 0, "x1234_x");
        step(1, 0, 1, "1", 2, 1, 1, 1, "x1234_1");
        step(1, 0, 1, "2", 2, 1, 2, 1, "x1234_2");
        step(1, 0, 1, "3", 2, 1, 3, 1, "x1234_3");
        step(1, 0, 1, "4", 3, 0, 0, 1, "x1234_4");
        step(1, 1, 0, "x", 0, 0, 0, 0, "reset_b2");
        step(1, 0, 1, "a", 1, 0, 0, 0, "sat_a");
        step(1, 0, 1, "1", 2, 1, 1, 1, "sat_1");
        step(1, 0, 1, " ", 0, 0, 0, 1, "sat_sp1");
        step(1, 0, 1, "b", 1, 0, 0, 1, "sat_b");
        step(1, 0, 1, "2", 2, 1, 1, 2, "sat_2");
        step(1, 0, 1, " ", 0, 0, 0, 2, "sat_sp2");
        step(1, 0, 1, "c", 1, 0, 0, 2, "sat_c");
        step(1, 0, 1, "3", 2, 1, 1, 3, "sat_3");
        step(1, 0, 1, " ", 0, 0, 0, 3, "sat_sp3");
        step(1, 0, 1, "d", 1, 0, 0, 3, "sat_d");
        step(1, 0, 1, "4", 2, 1, 1, 3, "sat_4");
        step(1, 0, 1, " ", 0, 0, 0, 3, "sat_sp4");
        step(1, 1, 0, "x", 0, 0, 0, 0, "reset_b3");

        @(negedge clk);
        rst_b = 1'b0; vld_b = 1'b0;
        stim_done = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_scanner.md
ID_SCANNER -- requirements
Module: id_scanner

Interface
REQ-001 SHALL have parameter MAX_DIGITS, default 8, max digits accepted in one identifier suffix (legal range 1..255).
REQ-002 SHALL have parameter CNT_W, default 16, width of the match counter.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port char  input  8  ASCII character under test.
REQ-006 SHALL have port char_valid  input  1  char is consumed on a rising edge when high.
REQ-007 SHALL have port out  output  1  high while the accepted stream ends in letters followed by 1..MAX_DIGITS digits.
REQ-008 SHALL have port state  output  2  current FSM state: IDLE=0, ALPHA=1, DIGIT=2, ERR=3.
REQ-009 SHALL have port digit_cnt  output  $clog2(MAX_DIGITS+1)  digits in the current suffix run.
REQ-010 SHALL have port match_cnt  output  CNT_W  number of identifiers recognised since reset.

Function
REQ-011 SHALL classify char as: letter 'a'-'z'/'A'-'Z'; digit '0'-'9'; anything else separator.
REQ-012 SHALL change no register in a cycle with char_valid low.
REQ-013 SHALL, from IDLE: letter->ALPHA; digit->ERR; separator->IDLE.
REQ-014 SHALL, from ALPHA: letter->ALPHA; digit->DIGIT with digit_cnt=1; separator->IDLE.
REQ-015 SHALL, from DIGIT: digit with digit_cnt<MAX_DIGITS->DIGIT, digit_cnt+1; digit with digit_cnt==MAX_DIGITS->ERR (overflow); letter->ALPHA (new run); separator->IDLE.
REQ-016 SHALL, from ERR: digit->ERR; letter->ALPHA; separator->IDLE.
REQ-017 SHALL clear digit_cnt to 0 on every transition into IDLE, ALPHA or ERR.
REQ-018 SHALL drive out registered (Moore): out=1 exactly when state==DIGIT; out rises the cycle after the first valid digit following a letter.
REQ-019 SHALL increment match_cnt by 1 on each ALPHA->DIGIT transition only; DIGIT->DIGIT does not increment.
REQ-020 SHALL saturate match_cnt at 2^CNT_W-1 (no wrap).

Reset
REQ-021 SHALL, on rising clk with reset high, set state=IDLE, out=0, digit_cnt=0, match_cnt=0, regardless of char_valid.
REQ-022 SHALL let reset take priority over any in-progress token; the next accepted char after reset is treated as start-of-stream.

Configuration
REQ-023 SHALL, with macro ID_SCANNER_UNDERSCORE_EN defined, classify '_' (0x5F) as a letter; without it, '_' is a separator.

Verification
REQ-024 SHALL cover: reset, then valid stream "ab12" -> out 0,0,1,1 after each char; match_cnt=1; digit_cnt=2.
REQ-025 SHALL cover: stream "9a1 " -> states ERR,ALPHA,DIGIT,IDLE; out high only after '1'; match_cnt=1.
REQ-026 SHALL cover: MAX_DIGITS=3, stream "x1234" -> out 1 after '1','2','3', state ERR and out 0 after '4'; match_cnt=1.
REQ-027 SHALL cover: "a1" with char_valid low for 5 cycles between chars -> outputs hold; then reset high mid-DIGIT -> all outputs 0 next edge.
REQ-028 SHALL cover: CNT_W=2, stream "a1 b2 c3 d4 " -> match_cnt 1,2,3,3 (saturated).
REQ-029 SHALL cover: stream "_a1" -> with ID_SCANNER_UNDERSCORE_EN state ALPHA after '_'; without, IDLE after '_'; both end with out=1.
